wb_regfile: RTL

Write-back stage and general-purpose register file of the 5-stage MIPS pipeline. Consumes the registered MEM/WB bundle (control bits, memory read data, ALU result, destination register), selects the write-back value, and commits it to a 32 x 32-bit register file. Serves two combinational read ports to the ID stage. `$0` is hard-wired to zero. An optional write-to-read bypass removes the WB to ID structural hazard.

---
 rtl/mips_pkg.sv | 13 +
 rtl/wb_mux.sv | 17 +
 rtl/wb_regfile.sv | 65 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default bus widths, the $0 register index
// and the register-index type used by the decoder, hazard unit and register file.
package mips_pkg;

   localparam int unsigned MIPS_DW = 32;
   localparam int unsigned MIPS_AW = 5;

   // Architectural zero register; reads as 0, writes are dropped.
   localparam logic [MIPS_AW-1:0] REG_ZERO = 5'd0;

   typedef logic [MIPS_AW-1:0] reg_idx_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back select: memory read data or ALU result. Also reused by the
// forwarding path, so it carries no state and no enable.
module wb_mux #(
   parameter int unsigned DW = 32
) (
   input  logic          sel,
   input  logic [DW-1:0] mem_data,
   input  logic [DW-1:0] alu_data,
   output logic [DW-1:0] wb_data
);

   // 2:1 select, always driven regardless of the write enable
   always_comb begin
      wb_data = sel ? mem_data : alu_data;
   end

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage plus 32-entry general-purpose register file.
// One write port fed from MEM/WB, two combinational read ports for ID.
// Define WB_REGFILE_BYPASS_EN to forward the value being written this cycle
// straight to the read ports, removing the WB->ID stall.
module wb_regfile
   import mips_pkg::*;
#(
   parameter int unsigned DW = MIPS_DW,
   parameter int unsigned AW = MIPS_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemtoReg4,
   input  logic          RegWrite4,
   input  logic [DW-1:0] Data_out4,
   input  logic [DW-1:0] ALU_out4,
   input  logic [AW-1:0] RW4,
   input  logic [AW-1:0] RA,
   input  logic [AW-1:0] RB,
   output logic [DW-1:0] busA,
   output logic [DW-1:0] busB,
   output logic [DW-1:0] busW
);

   localparam int unsigned   Depth   = 2 ** AW;
   localparam logic [AW-1:0] IdxZero = AW'(REG_ZERO);

   logic [DW-1:0] regs [Depth];
   logic          wr_en;

   wb_mux #(
      .DW(DW)
   ) u_wb_mux (
      .sel      (MemtoReg4),
      .mem_data (Data_out4),
      .alu_data (ALU_out4),
      .wb_data  (busW)
   );

   // Writes to $0 never reach the array, so entry 0 stays zero forever
   assign wr_en = RegWrite4 && (RW4 != IdxZero);

   // Register array: async clear of every entry, single write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(Depth); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[RW4] <= busW;
      end
   end

   // Read ports: $0 forced to zero, optional same-cycle write bypass
   always_comb begin
      busA = (RA == IdxZero) ? '0 : regs[RA];
      busB = (RB == IdxZero) ? '0 : regs[RB];
`ifdef WB_REGFILE_BYPASS_EN
      // Bypass is gated by rst so the ports still read 0 while in reset
      if (rst && wr_en && (RW4 == RA)) busA = busW;
      if (rst && wr_en && (RW4 == RB)) busB = busW;
`endif
   end

endmodule
